mem_access_stage: RTL and testbench
===================================

MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Clock and reset SHALL be `clk` and `reset`: a single clock domain, with reset asynchronous and active-high.
REQ-002 Port list (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- alu_result  in  64  EX/MEM ALU result, used as load/store address or writeback value
- store_data  in  64  EX/MEM store data
- rd_in  in  5  EX/MEM destination register
- memread_in, memwrite_in, memtoreg_in, regwrite_in, branch_in, zero_in  in  1 each  EX/MEM control
- branch_target_in  in  64  EX/MEM adder output
- mem_req  out  1  data-bus request
- mem_we  out  1  1 = write
- mem_addr  out  64  bus address
- mem_wdata  out  64  bus write data
- mem_ready  in  1  bus completion
- mem_err  in  1  bus error, valid with mem_ready
- mem_rdata  in  64  bus read data, valid with mem_ready
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- pcsrc  out  1  taken branch
- branch_target  out  64  next PC when pcsrc=1
- wb_data  out  64  MEM/WB writeback value
- wb_rd  out  5  MEM/WB destination register
- wb_regwrite  out  1  MEM/WB write enable
- bus_error  out  1  one-cycle error pulse

Function
REQ-003 `access` SHALL be defined as memread_in | memwrite_in; if both are set, the access SHALL be treated as a write.
REQ-004 The FSM SHALL have three states, IDLE, ACCESS and DONE, and SHALL reset to IDLE.
REQ-005 IDLE with access=1 SHALL transition to ACCESS; IDLE with access=0 SHALL remain in IDLE.
REQ-006 On entry to ACCESS, the block SHALL register mem_req=1, mem_we=memwrite_in, mem_addr=alu_result and mem_wdata=store_data.
REQ-007 These bus outputs SHALL hold stable in ACCESS until a cycle with mem_ready=1.
REQ-008 ACCESS with mem_ready=1 SHALL:
- capture mem_rdata into an internal load register;
- capture mem_err;
- drop mem_req on the next edge;
- transition to DONE.
REQ-009 ACCESS with mem_ready=0 SHALL remain in ACCESS; there SHALL be no timeout.
REQ-010 DONE SHALL transition unconditionally to IDLE. This prevents the same instruction from re-issuing while EX/MEM advances.
REQ-011 stall SHALL be combinational and equal (IDLE & access) | ACCESS; stall SHALL be 0 in DONE.
REQ-012 The MEM/WB registers (wb_data, wb_rd, wb_regwrite) SHALL update on every rising edge.
REQ-013 When stall=0, the MEM/WB registers SHALL load:
- wb_rd = rd_in;
- wb_data = memtoreg_in ? load register : alu_result;
- wb_regwrite = regwrite_in, forced to 0 if the captured mem_err=1.
REQ-014 When stall=1, wb_regwrite SHALL load 0 (bubble), and wb_data and wb_rd SHALL hold their values.
REQ-015 The loaded value SHALL be forwarded unmodified as 64 bits; there SHALL be no sub-word handling.
REQ-016 pcsrc SHALL equal branch_in & zero_in & ~stall, and branch_target SHALL equal branch_target_in; both outputs SHALL be combinational.
REQ-017 bus_error SHALL be a registered pulse that is 1 exactly during the DONE cycle when the captured mem_err=1.
REQ-018 Latency:
- A non-memory instruction SHALL reach the MEM/WB registers 1 edge after it is presented.
- A memory instruction SHALL take 2 + N stall cycles, where N is the number of ACCESS cycles with mem_ready=0.
REQ-019 mem_ready or mem_err asserted outside ACCESS SHALL be ignored.

Reset
REQ-020 Reset SHALL asynchronously force:
- state to IDLE;
- mem_req, mem_we, bus_error and wb_regwrite to 0;
- mem_addr, mem_wdata, wb_data, wb_rd and the load register to 0.
REQ-021 Reset asserted during ACCESS SHALL abandon the transfer, deassert mem_req immediately and discard any later mem_ready.
REQ-022 After reset deassertion, the first edge SHALL evaluate from IDLE.

Structure
REQ-023 A shared package `riscvy_pkg` SHALL hold:
- the XLEN=64 constant;
- REG_ADDR_W=5;
- the mem_state_t enum (IDLE, ACCESS, DONE).
REQ-024 A single sub-module `mem_wb_reg` SHALL implement REQ-012 to REQ-014 (enable plus bubble); the FSM and bus logic SHALL reside in the top level.

Verification
REQ-025 ALU op with alu_result=0x1234, rd_in=7, regwrite_in=1 -> after 1 edge: wb_data=0x1234, wb_rd=7, wb_regwrite=1; stall never asserts.
REQ-026 Load with addr 0x100, memtoreg_in=1, and mem_ready on the 3rd ACCESS cycle with rdata=0xDEADBEEF -> behaviour:
- stall=1 for 4 cycles;
- mem_addr=0x100 steady throughout ACCESS;
- wb_data=0xDEADBEEF after the DONE edge.
REQ-027 Store with addr 0x200, data 0xAA, mem_ready immediate -> mem_we=1 and mem_wdata=0xAA for one ACCESS cycle; wb_regwrite=0; exactly one mem_req transaction.
REQ-028 Load with mem_err=1 and mem_ready=1 -> bus_error pulses for 1 cycle; wb_regwrite=0.
REQ-029 reset asserted in ACCESS with mem_ready=1 on the same edge -> state=IDLE, mem_req=0, wb_regwrite=0, bus_error=0.
REQ-030 branch_in=1 and zero_in=1 with target 0x80 -> pcsrc=1 and branch_target=0x80 in the same cycle.

Source files
------------

// File: rtl/riscvy_pkg.sv
// Shared pipeline constants and the memory-stage FSM state type.
// Imported by the MEM stage, its bus interface and the MEM/WB register.
package riscvy_pkg;

   localparam int unsigned XLEN       = 64;
   localparam int unsigned REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_t;

   // A set memwrite wins over memread; both still count as one access.
   function automatic logic is_access(input logic memread, input logic memwrite);
      return memread | memwrite;
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-bus signals between the MEM stage (master) and the memory system (slave).
interface mem_access_stage_if;

   logic                        mem_req;
   logic                        mem_we;
   logic [riscvy_pkg::XLEN-1:0] mem_addr;
   logic [riscvy_pkg::XLEN-1:0] mem_wdata;
   logic                        mem_ready;
   logic                        mem_err;
   logic [riscvy_pkg::XLEN-1:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ready, mem_err, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ready, mem_err, mem_rdata
   );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: loads every edge when not stalled, inserts a
// bubble (write enable cleared, data and rd held) when stalled.
module mem_wb_reg
   import riscvy_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  stall,
   input  logic [XLEN-1:0]       data_in,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic                  regwrite_in,
   output logic [XLEN-1:0]       wb_data,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  wb_regwrite
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_data     <= '0;
         wb_rd       <= '0;
         wb_regwrite <= 1'b0;
      end else if (stall) begin
         wb_regwrite <= 1'b0;
      end else begin
         wb_data     <= data_in;
         wb_rd       <= rd_in;
         wb_regwrite <= regwrite_in;
      end
   end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: runs one bus transfer per memory instruction, stalls the
// front of the pipe until it completes, and feeds the MEM/WB register.
module mem_access_stage
   import riscvy_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [XLEN-1:0]       alu_result,
   input  logic [XLEN-1:0]       store_data,
   input  logic [REG_ADDR_W-1:0] rd_in,
   input  logic                  memread_in,
   input  logic                  memwrite_in,
   input  logic                  memtoreg_in,
   input  logic                  regwrite_in,
   input  logic                  branch_in,
   input  logic                  zero_in,
   input  logic [XLEN-1:0]       branch_target_in,
   mem_access_stage_if.master    bus,
   output logic                  stall,
   output logic                  pcsrc,
   output logic [XLEN-1:0]       branch_target,
   output logic [XLEN-1:0]       wb_data,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  wb_regwrite,
   output logic                  bus_error
);

   mem_state_t      state_q;
   mem_state_t      state_d;
   logic            access;
   logic [XLEN-1:0] load_q;
   logic [XLEN-1:0] wb_data_d;
   logic            wb_regwrite_d;

   assign access = is_access(memread_in, memwrite_in);

   always_comb begin
      state_d = state_q;
      stall   = 1'b0;
      case (state_q)
         IDLE: begin
            if (access) begin
               state_d = ACCESS;
               stall   = 1'b1;
            end
         end
         ACCESS: begin
            stall = 1'b1;
            if (bus.mem_ready) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // bus_error doubles as the captured error flag: it is only ever set in DONE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         load_q        <= '0;
         bus_error     <= 1'b0;
      end else begin
         bus_error <= 1'b0;
         if (state_q == IDLE && access) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= memwrite_in;
            bus.mem_addr  <= alu_result;
            bus.mem_wdata <= store_data;
         end
         if (state_q == ACCESS && bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            load_q      <= bus.mem_rdata;
            bus_error   <= bus.mem_err;
         end
      end
   end

   assign wb_data_d     = memtoreg_in ? load_q : alu_result;
   assign wb_regwrite_d = regwrite_in & ~bus_error;

   assign pcsrc         = branch_in & zero_in & ~stall;
   assign branch_target = branch_target_in;

   mem_wb_reg u_mem_wb_reg (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .data_in     (wb_data_d),
      .rd_in       (rd_in),
      .regwrite_in (wb_regwrite_d),
      .wb_data     (wb_data),
      .wb_rd       (wb_rd),
      .wb_regwrite (wb_regwrite)
   );

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: a driver issues directed and random
// instructions and predicts MEM/WB results; a monitor checks each retirement.
module tb_mem_access_stage;
   import riscvy_pkg::*;

   typedef struct {
      logic [63:0] alu, sd, bt, rdata;
      logic [4:0]  rd;
      logic        mr, mw, mtr, rw, br, z, err;
      int unsigned waits;
   } instr_t;

   typedef struct {
      logic [63:0] data;
      logic [4:0]  rd;
      logic        rw;
   } wb_exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] alu_result, store_data, branch_target_in;
   logic [4:0]  rd_in;
   logic        memread_in, memwrite_in, memtoreg_in, regwrite_in, branch_in, zero_in;
   logic        stall, pcsrc, wb_regwrite, bus_error;
   logic [63:0] branch_target, wb_data;
   logic [4:0]  wb_rd;

   mem_access_stage_if bus_if ();

   mem_access_stage dut (
      .clk              (clk),
      .reset            (reset),
      .alu_result       (alu_result),
      .store_data       (store_data),
      .rd_in            (rd_in),
      .memread_in       (memread_in),
      .memwrite_in      (memwrite_in),
      .memtoreg_in      (memtoreg_in),
      .regwrite_in      (regwrite_in),
      .branch_in        (branch_in),
      .zero_in          (zero_in),
      .branch_target_in (branch_target_in),
      .bus              (bus_if),
      .stall            (stall),
      .pcsrc            (pcsrc),
      .branch_target    (branch_target),
      .wb_data          (wb_data),
      .wb_rd            (wb_rd),
      .wb_regwrite      (wb_regwrite),
      .bus_error        (bus_error)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   wb_exp_t     exp_q[$];
   logic        mon_en     = 1'b0;
   logic        prev_valid = 1'b0;
   logic        prev_stall = 1'b0;
   logic [63:0] hold_data  = '0;
   logic [4:0]  hold_rd    = '0;
   logic [63:0] last_load  = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic instr_t mk(input logic [63:0] alu, input logic [63:0] sd,
                                 input logic [4:0] rd, input logic mr, input logic mw,
                                 input logic mtr, input logic rw, input logic br,
                                 input logic z, input logic [63:0] bt,
                                 input int unsigned waits, input logic err,
                                 input logic [63:0] rdata);
      instr_t t;
      t.alu = alu; t.sd = sd; t.rd = rd; t.mr = mr; t.mw = mw; t.mtr = mtr;
      t.rw = rw; t.br = br; t.z = z; t.bt = bt; t.waits = waits; t.err = err;
      t.rdata = rdata;
      return t;
   endfunction

   function automatic instr_t rand_instr();
      return mk({$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                {$urandom, $urandom}, $urandom_range(0, 3),
                ($urandom_range(0, 4) == 0), {$urandom, $urandom});
   endfunction

   task automatic apply(input instr_t t);
      alu_result = t.alu; store_data = t.sd; rd_in = t.rd;
      memread_in = t.mr; memwrite_in = t.mw; memtoreg_in = t.mtr;
      regwrite_in = t.rw; branch_in = t.br; zero_in = t.z; branch_target_in = t.bt;
   endtask

   task automatic noise();
      bus_if.mem_ready = 1'($urandom_range(0, 1));
      bus_if.mem_err   = 1'($urandom_range(0, 1));
      bus_if.mem_rdata = {$urandom, $urandom};
   endtask

   // Instruction enters in IDLE; memory ops then spend waits+1 ACCESS cycles and one DONE cycle.
   task automatic issue(input instr_t t);
      wb_exp_t     e;
      logic        acc;
      acc = t.mr | t.mw;
      @(posedge clk); #1;
      apply(t);
      noise();
      mon_en = 1'b1;
      if (acc) last_load = t.rdata;
      e.data = t.mtr ? last_load : t.alu;
      e.rd   = t.rd;
      e.rw   = t.rw & ~(acc & t.err);
      exp_q.push_back(e);
      @(negedge clk);
      chk("issue_stall", stall, acc);
      chk("issue_pcsrc", pcsrc, t.br & t.z & ~acc);
      chk("branch_target", branch_target, t.bt);
      chk("issue_mem_req", bus_if.mem_req, 0);
      chk("issue_bus_error", bus_error, 0);
      if (acc) begin
         for (int unsigned i = 0; i <= t.waits; i++) begin
            @(posedge clk); #1;
            bus_if.mem_ready = (i == t.waits);
            bus_if.mem_err   = (i == t.waits) ? t.err : 1'($urandom_range(0, 1));
            bus_if.mem_rdata = (i == t.waits) ? t.rdata : {$urandom, $urandom};
            @(negedge clk);
            chk("acc_stall", stall, 1);
            chk("acc_pcsrc", pcsrc, 0);
            chk("acc_mem_req", bus_if.mem_req, 1);
            chk("acc_mem_we", bus_if.mem_we, t.mw);
            chk("acc_mem_addr", bus_if.mem_addr, t.alu);
            chk("acc_mem_wdata", bus_if.mem_wdata, t.sd);
         end
         @(posedge clk); #1;
         noise();
         @(negedge clk);
         chk("done_stall", stall, 0);
         chk("done_mem_req", bus_if.mem_req, 0);
         chk("done_bus_error", bus_error, t.err);
         chk("done_pcsrc", pcsrc, t.br & t.z);
      end
   endtask

   task automatic drain();
      @(posedge clk); #1;
      apply(mk('0, '0, '0, 0, 0, 0, 0, 0, 0, '0, 0, 0, '0));
      bus_if.mem_ready = 1'b0;
      @(negedge clk); #1;
      chk("queue_drained", exp_q.size(), 0);
      mon_en = 1'b0;
   endtask

   initial begin : monitor
      wb_exp_t e;
      forever begin
         @(negedge clk);
         if (!mon_en) begin
            prev_valid = 1'b0;
         end else begin
            if (prev_valid) begin
               if (!prev_stall) begin
                  if (exp_q.size() == 0) begin
                     checks++;
                     failures++;
                     $display("FAIL unexpected_retire: got retire with wb_rd %0d expected none", wb_rd);
                  end else begin
                     e = exp_q.pop_front();
                     chk("wb_data", wb_data, e.data);
                     chk("wb_rd", 64'(wb_rd), 64'(e.rd));
                     chk("wb_regwrite", wb_regwrite, e.rw);
                     hold_data = e.data;
                     hold_rd   = e.rd;
                  end
               end else begin
                  chk("bubble_regwrite", wb_regwrite, 0);
                  chk("bubble_data_hold", wb_data, hold_data);
                  chk("bubble_rd_hold", 64'(wb_rd), 64'(hold_rd));
               end
            end
            prev_stall = stall;
            prev_valid = 1'b1;
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      reset = 1'b1;
      apply(mk('0, '0, '0, 0, 0, 0, 0, 0, 0, '0, 0, 0, '0));
      bus_if.mem_ready = 1'b0;
      bus_if.mem_err   = 1'b0;
      bus_if.mem_rdata = '0;
      repeat (2) @(negedge clk);
      chk("rst_mem_req", bus_if.mem_req, 0);
      chk("rst_mem_we", bus_if.mem_we, 0);
      chk("rst_mem_addr", bus_if.mem_addr, 0);
      chk("rst_mem_wdata", bus_if.mem_wdata, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_rd", 64'(wb_rd), 0);
      chk("rst_wb_regwrite", wb_regwrite, 0);
      chk("rst_bus_error", bus_error, 0);
      chk("rst_stall", stall, 0);
      @(posedge clk); #1;
      reset = 1'b0;

      // Directed: ALU op, slow load, store, errored load, branch, read+write, stale load reg.
      issue(mk(64'h1234, 64'h0, 5'd7, 0, 0, 0, 1, 0, 0, 64'h40, 0, 0, 64'h0));
      issue(mk(64'h100, 64'h0, 5'd3, 1, 0, 1, 1, 0, 0, 64'h0, 2, 0, 64'hDEADBEEF));
      issue(mk(64'h200, 64'hAA, 5'd0, 0, 1, 0, 0, 0, 0, 64'h0, 0, 0, 64'h0));
      issue(mk(64'h300, 64'h0, 5'd12, 1, 0, 1, 1, 0, 0, 64'h0, 1, 1, 64'hBAD0BAD0));
      issue(mk(64'h0, 64'h0, 5'd0, 0, 0, 0, 0, 1, 1, 64'h80, 0, 0, 64'h0));
      issue(mk(64'h408, 64'h5A5A, 5'd4, 1, 1, 0, 0, 1, 1, 64'h90, 0, 0, 64'h77));
      issue(mk(64'h500, 64'h0, 5'd9, 1, 0, 1, 1, 0, 0, 64'h0, 0, 0, 64'hCAFEF00D));
      issue(mk(64'h999, 64'h0, 5'd10, 0, 0, 1, 1, 0, 0, 64'h0, 0, 0, 64'h0));
      for (int i = 0; i < 150; i++) issue(rand_instr());
      drain();

      // Reset while a load is in ACCESS and the bus completes on the reset edge.
      @(posedge clk); #1;
      apply(mk(64'h300, 64'h0, 5'd9, 1, 0, 1, 1, 0, 0, 64'h0, 0, 0, 64'h0));
      bus_if.mem_ready = 1'b0;
      @(negedge clk);
      chk("rst_test_idle_stall", stall, 1);
      @(posedge clk); #1;
      bus_if.mem_ready = 1'b1;
      bus_if.mem_err   = 1'b1;
      bus_if.mem_rdata = 64'h5555;
      @(negedge clk);
      chk("rst_test_req_before", bus_if.mem_req, 1);
      #1 reset = 1'b1;
      #1 chk("rst_async_mem_req", bus_if.mem_req, 0);
      @(posedge clk); #1;
      apply(mk('0, '0, '0, 0, 0, 0, 0, 0, 0, '0, 0, 0, '0));
      @(negedge clk);
      chk("rst_acc_stall", stall, 0);
      chk("rst_acc_mem_req", bus_if.mem_req, 0);
      chk("rst_acc_bus_error", bus_error, 0);
      chk("rst_acc_wb_regwrite", wb_regwrite, 0);
      chk("rst_acc_wb_data", wb_data, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_stall", stall, 0);
      chk("post_rst_mem_req", bus_if.mem_req, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_rst_ignored_ready", bus_error, 0);
      chk("post_rst_mem_req2", bus_if.mem_req, 0);

      exp_q.delete();
      hold_data = '0;
      hold_rd   = '0;
      last_load = '0;
      issue(mk(64'h77, 64'h0, 5'd5, 0, 0, 1, 1, 0, 0, 64'h0, 0, 0, 64'h0));
      for (int i = 0; i < 60; i++) issue(rand_instr());
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
